keypad_calc_ctrl: RTL and testbench
===================================

Name: keypad_calc_ctrl

Overview:
- Parametrised keypad-driven controller for the calculator datapath.
- Key codes drive BCD operand entry into NUM_OPS operand registers, register selection, and operation selection.
- Launches the ALU via a start/done handshake and holds until key release and completion.
- Sits between the keypad scanner and the ALU/display path.

Parameters:
- NUM_OPS, 2: number of operand registers; min 2.
- DIGITS, 4: BCD digits per operand register; min 1.
- TIMEOUT, 1024: max cycles in CALC before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- key  in  5  scanner code: 0x00-0x0F = keys 0-F; any code >= 0x10 = no key.
- calc_done  in  1  ALU completion; level or pulse, sampled only in CALC.
- calc_start  out  1  one-cycle ALU launch pulse.
- op_sel  out  3  0 none, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
- reg_sel  out  max(1,clog2(NUM_OPS))  currently selected operand register.
- opnd_bus  out  NUM_OPS*DIGITS*4  operand registers; reg i at bits [i*DIGITS*4 +: DIGITS*4].
- state  out  3  0 IDLE, 1 HOLD, 2 OP_HOLD, 3 CALC, 4 ERR.
- busy  out  1  high in OP_HOLD and CALC.
- err  out  1  timeout flag; tied 0 when the optional feature is off.

Behaviour:
- Reset values: state=IDLE, op_sel=0, reg_sel=0, all operands 0, all digit counts 0, fresh flags 0, calc_start=0, err=0, done_seen=0.
- Reset mid-CALC aborts without a further calc_start.
- IDLE, digit key 0x0-0x9:
  - If the selected register's fresh flag is set: clear that register, set its count to 1, write the digit in the low nibble, clear fresh.
  - Else if count < DIGITS: shift the register left 4 bits, insert the digit in the low nibble, count+1.
  - Else (full): value unchanged.
  - In all cases go to HOLD.
- IDLE, key A: reg_sel = (reg_sel+1) mod NUM_OPS; go to HOLD.
- IDLE, keys B-F: latch op_sel = key-0xA (B=1 … F=5); go to OP_HOLD.
- IDLE, no key: remain.
- HOLD: remain while any key is present; no key -> IDLE. Each press therefore acts exactly once.
- OP_HOLD: remain while any key is present.
- OP_HOLD, no key: go to CALC and assert calc_start for exactly that transition cycle (registered, high during the first CALC cycle).
- CALC:
  - Keys ignored.
  - done_seen is set by calc_done in any CALC cycle, including the first.
  - Exit to IDLE on the first cycle where (done_seen or calc_done) and no key.
  - On exit: set all fresh flags, clear done_seen; op_sel and operand values are retained.
- Simultaneous events: a key change and calc_done in the same cycle are both honoured. done_seen latches; the exit waits for release.
- busy is combinational from state.

Optional Feature:
- Macro: KEYPAD_CALC_TIMEOUT_EN.
- Defined:
  - A counter clears on CALC entry and increments each CALC cycle.
  - If the count reaches TIMEOUT-1 without done seen: go to ERR, err=1, op_sel=0.
  - ERR: any key -> HOLD with err cleared; no other effect.
  - A calc_done arriving in ERR is ignored.
- Undefined: no counter, ERR unreachable, err tied 0, CALC waits indefinitely.

Test Plan:
- Reset, then keys 1,2,3 each followed by a release cycle -> opnd reg0 = 0x0123, state back to 0 after each release.
- With DIGITS=4, enter 1,2,3,4,5 -> reg0 = 0x1234 (fifth digit ignored), state still passes through HOLD.
- Key A, release, enter 7 -> reg_sel=1, reg1 = 0x0007, reg0 unchanged. With NUM_OPS=2, a second A -> reg_sel=0.
- Key C held 3 cycles then released -> op_sel=2, calc_start high exactly one cycle; calc_done 5 cycles later -> IDLE. Next digit 9 -> reg0 = 0x0009.
- calc_done pulsed in the first CALC cycle while key 4 is pressed -> stays in CALC until release, then IDLE; the digit is not entered.
- With KEYPAD_CALC_TIMEOUT_EN and TIMEOUT=16: start an op with no calc_done -> ERR and err=1 after 16 CALC cycles, op_sel=0. Key 0 -> HOLD, err=0. rst asserted mid-CALC -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/keypad_calc_ctrl_if.sv
// Keypad controller bus: scanner key code and ALU handshake in, operand/status view out.
// slave = controller side, master = keypad/ALU/display environment side.
interface keypad_calc_ctrl_if #(
  parameter int NUM_OPS = 2,
  parameter int DIGITS  = 4
);
  localparam int REG_SEL_W = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1;

  logic [4:0]                  key;
  logic                        calc_done;
  logic                        calc_start;
  logic [2:0]                  op_sel;
  logic [REG_SEL_W-1:0]        reg_sel;
  logic [NUM_OPS*DIGITS*4-1:0] opnd_bus;
  logic [2:0]                  state;
  logic                        busy;
  logic                        err;

  modport master (
    output key, calc_done,
    input  calc_start, op_sel, reg_sel, opnd_bus, state, busy, err
  );

  modport slave (
    input  key, calc_done,
    output calc_start, op_sel, reg_sel, opnd_bus, state, busy, err
  );
endinterface

// File: rtl/keypad_calc_ctrl.sv
// Keypad-driven BCD operand entry and ALU launch controller.
// Optional CALC timeout/ERR state enabled by defining KEYPAD_CALC_TIMEOUT_EN.
module keypad_calc_ctrl #(
  parameter int NUM_OPS = 2,
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  keypad_calc_ctrl_if.slave  bus
);
  localparam int REG_SEL_W = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1;
  localparam int REG_W     = DIGITS * 4;
  localparam int CNT_W     = $clog2(DIGITS + 1);

  if (NUM_OPS < 2 || DIGITS < 1 || TIMEOUT < 2) begin : g_param_check
    $error("keypad_calc_ctrl: NUM_OPS>=2, DIGITS>=1, TIMEOUT>=2 required");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    OP_HOLD = 3'd2,
    CALC    = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t                            st;
  logic [NUM_OPS-1:0][REG_W-1:0]     opnd;
  logic [NUM_OPS-1:0][CNT_W-1:0]     cnt;
  logic [NUM_OPS-1:0]                fresh;
  logic [REG_SEL_W-1:0]              reg_sel;
  logic [2:0]                        op_sel;
  logic                              calc_start;
  logic                              done_seen;

  logic key_valid;
  logic is_digit;
  logic done_any;

  assign key_valid = ~bus.key[4];
  assign is_digit  = key_valid && (bus.key[3:0] <= 4'd9);
  assign done_any  = done_seen | bus.calc_done;

`ifdef KEYPAD_CALC_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      opnd       <= '0;
      cnt        <= '0;
      fresh      <= '0;
      reg_sel    <= '0;
      op_sel     <= '0;
      calc_start <= 1'b0;
      done_seen  <= 1'b0;
`ifdef KEYPAD_CALC_TIMEOUT_EN
      to_cnt     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      calc_start <= 1'b0;
      case (st)
        IDLE: begin
          if (is_digit) begin
            // First digit after a calculation replaces the old result.
            if (fresh[reg_sel]) begin
              opnd[reg_sel]  <= REG_W'(bus.key[3:0]);
              cnt[reg_sel]   <= CNT_W'(1);
              fresh[reg_sel] <= 1'b0;
            end else if (cnt[reg_sel] < CNT_W'(DIGITS)) begin
              opnd[reg_sel] <= (opnd[reg_sel] << 4) | REG_W'(bus.key[3:0]);
              cnt[reg_sel]  <= cnt[reg_sel] + CNT_W'(1);
            end
            st <= HOLD;
          end else if (key_valid && bus.key[3:0] == 4'hA) begin
            reg_sel <= (reg_sel == REG_SEL_W'(NUM_OPS - 1)) ? '0 : reg_sel + REG_SEL_W'(1);
            st      <= HOLD;
          end else if (key_valid) begin
            op_sel <= bus.key[2:0] - 3'd2;
            st     <= OP_HOLD;
          end
        end
        HOLD: begin
          if (!key_valid) st <= IDLE;
        end
        OP_HOLD: begin
          if (!key_valid) begin
            st         <= CALC;
            calc_start <= 1'b1;
`ifdef KEYPAD_CALC_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        CALC: begin
          if (done_any && !key_valid) begin
            st        <= IDLE;
            fresh     <= '1;
            done_seen <= 1'b0;
          end
`ifdef KEYPAD_CALC_TIMEOUT_EN
          else if (!done_any && to_cnt == TO_W'(TIMEOUT - 1)) begin
            st     <= ERR;
            err_q  <= 1'b1;
            op_sel <= '0;
          end
`endif
          else begin
            done_seen <= done_any;
`ifdef KEYPAD_CALC_TIMEOUT_EN
            to_cnt    <= to_cnt + TO_W'(1);
`endif
          end
        end
        ERR: begin
`ifdef KEYPAD_CALC_TIMEOUT_EN
          if (key_valid) begin
            st    <= HOLD;
            err_q <= 1'b0;
          end
`else
          st <= IDLE;
`endif
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.calc_start = calc_start;
  assign bus.op_sel     = op_sel;
  assign bus.reg_sel    = reg_sel;
  assign bus.opnd_bus   = opnd;
  assign bus.state      = st;
  assign bus.busy       = (st == OP_HOLD) || (st == CALC);
`ifdef KEYPAD_CALC_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_calc_ctrl.sv
// Self-checking bench for keypad_calc_ctrl: per-cycle vector table through a
// scoreboard queue, plus directed timeout/ERR and mid-CALC reset sequences.
module tb_keypad_calc_ctrl;
  localparam int NUM_OPS = 2;
  localparam int DIGITS  = 4;
  localparam int TIMEOUT = 16;
  localparam logic [4:0] NK = 5'h1F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_calc_ctrl_if #(.NUM_OPS(NUM_OPS), .DIGITS(DIGITS)) bus ();

  keypad_calc_ctrl #(.NUM_OPS(NUM_OPS), .DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  key;
    logic        done;
    logic [2:0]  st;
    logic [2:0]  op;
    logic        rs;
    logic [15:0] r0;
    logic [15:0] r1;
    logic        start;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic [4:0] k, logic d, logic [2:0] s, logic [2:0] o,
                              logic rs, logic [15:0] r0, logic [15:0] r1, logic cs);
    vec_t v;
    v.key = k; v.done = d; v.st = s; v.op = o; v.rs = rs; v.r0 = r0; v.r1 = r1; v.start = cs;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: queue empty, got 0 entries expected 1");
      return;
    end
    e = exp_q.pop_front();
    compare("state",      32'(bus.state),      32'(e.st));
    compare("op_sel",     32'(bus.op_sel),     32'(e.op));
    compare("reg_sel",    32'(bus.reg_sel),    32'(e.rs));
    compare("opnd_bus",   32'(bus.opnd_bus),   {e.r1, e.r0});
    compare("calc_start", 32'(bus.calc_start), 32'(e.start));
    compare("busy",       32'(bus.busy),       32'(e.st == 3'd2 || e.st == 3'd3));
    compare("err",        32'(bus.err),        32'd0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    bus.key       = v.key;
    bus.calc_done = v.done;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic step(input logic [4:0] k, input logic d);
    @(negedge clk);
    bus.key       = k;
    bus.calc_done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.key       = NK;
    bus.calc_done = 1'b0;

    // key, done -> state, op_sel, reg_sel, reg0, reg1, calc_start
    vecs.push_back(mk(5'h01, 0, 1, 0, 0, 16'h0001, 16'h0000, 0));
    vecs.push_back(mk(NK,    0, 0, 0, 0, 16'h0001, 16'h0000, 0));
    vecs.push_back(mk(5'h02, 0, 1, 0, 0, 16'h0012, 16'h0000, 0));
    vecs.push_back(mk(5'h10, 0, 0, 0, 0, 16'h0012, 16'h0000, 0));
    vecs.push_back(mk(5'h03, 0, 1, 0, 0, 16'h0123, 16'h0000, 0));
    vecs.push_back(mk(NK,    0, 0, 0, 0, 16'h0123, 16'h0000, 0));
    vecs.push_back(mk(5'h04, 0, 1, 0, 0, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(NK,    0, 0, 0, 0, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(5'h05, 0, 1, 0, 0, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(5'h05, 0, 1, 0, 0, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(NK,    0, 0, 0, 0, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(5'h0A, 0, 1, 0, 1, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(NK,    0, 0, 0, 1, 16'h1234, 16'h0000, 0));
    vecs.push_back(mk(5'h07, 0, 1, 0, 1, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 0, 0, 1, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(5'h0A, 0, 1, 0, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 0, 0, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(5'h0C, 0, 2, 2, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(5'h0C, 0, 2, 2, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(5'h0C, 0, 2, 2, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 3, 2, 0, 16'h1234, 16'h0007, 1));
    vecs.push_back(mk(NK,    0, 3, 2, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 3, 2, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 3, 2, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 3, 2, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(NK,    1, 0, 2, 0, 16'h1234, 16'h0007, 0));
    vecs.push_back(mk(5'h09, 0, 1, 2, 0, 16'h0009, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 0, 2, 0, 16'h0009, 16'h0007, 0));
    vecs.push_back(mk(5'h08, 0, 1, 2, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 0, 2, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(5'h0F, 0, 2, 5, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 3, 5, 0, 16'h0098, 16'h0007, 1));
    vecs.push_back(mk(5'h04, 1, 3, 5, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(5'h04, 0, 3, 5, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 0, 5, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(NK,    1, 0, 5, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(5'h0D, 0, 2, 3, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 3, 3, 0, 16'h0098, 16'h0007, 1));
    vecs.push_back(mk(NK,    0, 3, 3, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(NK,    1, 0, 3, 0, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(5'h0A, 0, 1, 3, 1, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(NK,    0, 0, 3, 1, 16'h0098, 16'h0007, 0));
    vecs.push_back(mk(5'h06, 0, 1, 3, 1, 16'h0098, 16'h0006, 0));
    vecs.push_back(mk(NK,    0, 0, 3, 1, 16'h0098, 16'h0006, 0));

    repeat (2) @(posedge clk);
    #1;
    compare("reset state",      32'(bus.state),      32'd0);
    compare("reset op_sel",     32'(bus.op_sel),     32'd0);
    compare("reset reg_sel",    32'(bus.reg_sel),    32'd0);
    compare("reset opnd_bus",   32'(bus.opnd_bus),   32'd0);
    compare("reset calc_start", 32'(bus.calc_start), 32'd0);
    compare("reset busy",       32'(bus.busy),       32'd0);
    compare("reset err",        32'(bus.err),        32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);
    compare("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // Launch ADD with no completion: timeout build aborts, default build waits.
    step(5'h0B, 0);
    compare("op B op_sel", 32'(bus.op_sel), 32'd1);
    step(NK, 0);
    compare("op B enters CALC", 32'(bus.state), 32'd3);
`ifdef KEYPAD_CALC_TIMEOUT_EN
    repeat (TIMEOUT - 1) step(NK, 0);
    compare("CALC before timeout", 32'(bus.state), 32'd3);
    compare("err before timeout",  32'(bus.err),   32'd0);
    step(NK, 0);
    compare("timeout state ERR", 32'(bus.state),  32'd4);
    compare("timeout err",       32'(bus.err),    32'd1);
    compare("timeout op_sel",    32'(bus.op_sel), 32'd0);
    compare("ERR busy",          32'(bus.busy),   32'd0);
    step(NK, 1);
    compare("ERR ignores done", 32'(bus.state), 32'd4);
    step(5'h00, 0);
    compare("ERR key -> HOLD",   32'(bus.state),    32'd1);
    compare("ERR key clears err", 32'(bus.err),     32'd0);
    compare("ERR key no digit",  32'(bus.opnd_bus), 32'h0006_0098);
    step(NK, 0);
    compare("ERR release IDLE", 32'(bus.state), 32'd0);
`else
    repeat (40) step(NK, 0);
    compare("CALC waits indefinitely", 32'(bus.state), 32'd3);
    compare("err tied low",            32'(bus.err),   32'd0);
    step(NK, 1);
    compare("late done -> IDLE", 32'(bus.state), 32'd0);
`endif

    // Reset while in CALC must abort cleanly with no extra launch pulse.
    step(5'h0E, 0);
    step(NK, 0);
    compare("op E calc_start", 32'(bus.calc_start), 32'd1);
    step(NK, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    compare("midcalc rst state",      32'(bus.state),      32'd0);
    compare("midcalc rst op_sel",     32'(bus.op_sel),     32'd0);
    compare("midcalc rst reg_sel",    32'(bus.reg_sel),    32'd0);
    compare("midcalc rst opnd_bus",   32'(bus.opnd_bus),   32'd0);
    compare("midcalc rst calc_start", 32'(bus.calc_start), 32'd0);
    compare("midcalc rst busy",       32'(bus.busy),       32'd0);
    compare("midcalc rst err",        32'(bus.err),        32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(NK, 1);
    compare("post rst state",      32'(bus.state),      32'd0);
    compare("post rst calc_start", 32'(bus.calc_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
